pet_event_scheduler: RTL
========================

// Module: pet_event_scheduler
// PURPOSE
//  Sits directly downstream of the 8-bit LFSR random generator and consumes its rand_out byte.
//  Turns the random stream into timed pet events (hunger, boredom, sleepiness, sickness) for the game FSM.
//  Uses one random byte to pick a random gap in game ticks, and a second byte to pick a weighted event.
//  Holds each event until the game logic acknowledges it, and counts the ticks the event stays unserviced.
// PARAMETERS
//  MIN_GAP   8    minimum ticks between ARM and event (1..255)
//  GAP_BITS  4    number of rand_in LSBs added to MIN_GAP (1..8)
//  TH_HUNGER 96   rand_in < TH_HUNGER -> event 0 HUNGER
//  TH_BORED  160  rand_in < TH_BORED  -> event 1 BORED
//  TH_SLEEPY 224  rand_in < TH_SLEEPY -> event 2 SLEEPY; otherwise event 3 SICK
// PORTS
//  clk          in   1  system clock; all logic on the rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  enable       in   1  scheduler run enable (game active)
//  tick         in   1  one-clk game-tick pulse
//  rand_in      in   8  pseudo-random byte from the LFSR; changes every clk
//  event_ack    in   1  game logic has consumed the pending event
//  event_valid  out  1  an event is pending
//  event_id     out  2  0 HUNGER, 1 BORED, 2 SLEEPY, 3 SICK; valid while event_valid=1
//  miss_cnt     out  4  ticks seen while the event is pending; saturates at 15
//  busy         out  1  1 in any state other than IDLE
// BEHAVIOUR
//  Reset (rst_n=0, takes effect at once): state=IDLE; count=0; event_valid=0; event_id=0; miss_cnt=0; busy=0.
//  FSM states: IDLE, ARM, COUNT, PICK, PENDING.
//  IDLE: if enable=1 -> ARM on the next clk.
//   ARM (1 clk): count <= MIN_GAP + rand_in[GAP_BITS-1:0].
//    - Zero-extend the sum to 9 bits; it must never wrap.
//    - Go to COUNT.
//  COUNT: on tick=1 with count==1 -> PICK; on tick=1 otherwise -> count <= count-1.
//   - count never reaches 0 in COUNT.
//   - If enable=0 -> IDLE and count=0. This takes priority over tick.
//  PICK (1 clk): latch event_id from the rand_in value of that cycle, using the thresholds in unsigned compare.
//   - Go to PENDING and set event_valid=1 on the same edge.
//   - event_valid therefore rises 2 clks after the clk that sampled the final tick.
//  PENDING: event_valid=1 and event_id are held stable.
//   - tick=1 with no ack -> miss_cnt <= min(miss_cnt+1, 15).
//   - event_ack=1 -> event_valid=0, miss_cnt=0, then -> ARM if enable=1, else -> IDLE.
//   - ack and tick in the same clk: ack wins; miss_cnt is cleared, not incremented.
//   - enable=0 does NOT drop a pending event; it leaves PENDING only on ack.
//  event_ack outside PENDING is ignored. tick in IDLE/ARM/PICK is ignored (not counted).
//  The two bytes come from different clks (ARM, PICK), so gap and event are independently drawn.
//  Async reset mid-operation: every output returns to its reset value immediately; no event is replayed.
// TESTING
//  T1: assert rst_n=0 in any state -> event_valid=0, event_id=0, miss_cnt=0, busy=0 with no clk edge.
//  T2: enable=1, rand_in held 8'h05, tick every 4 clks -> interval 13 ticks.
//      event_valid rises 2 clks after the 13th tick; event_id=0 (HUNGER).
//  T3: rand_in held 8'hF0 -> interval 8 ticks, event_id=3 (SICK).
//      rand_in held 8'hA0 -> interval 8, event_id=2 (SLEEPY).
//      rand_in 8'h5F (<96) -> event_id=0 (HUNGER) at threshold edge.
//      rand_in 8'h60 (=96) -> event_id=1 (BORED) at threshold edge.
//  T4: leave event unacked for 3 ticks -> miss_cnt=3; for 20 ticks -> miss_cnt=15.
//      Ack together with a tick -> event_valid=0, miss_cnt=0, state ARM.
//  T5: drop enable after 5 of 13 ticks -> IDLE, busy=0, no event.
//      Re-enable -> fresh ARM samples a new gap.
//      Drop enable during PENDING -> event held until ack, then IDLE.
//  T6: pulse rst_n low while PENDING with miss_cnt=7 -> all outputs 0.
//      After release with enable=1, the next event needs a full new interval.

Source files
------------

// File: rtl/pet_event_scheduler.sv
//==============================================================================
// Module      : pet_event_scheduler
// Description : Turns the LFSR byte stream into randomly spaced, weighted pet
//               events that are held until acknowledged by the game FSM.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pet_event_scheduler #(
   parameter int MIN_GAP   = 8,
   parameter int GAP_BITS  = 4,
   parameter int TH_HUNGER = 96,
   parameter int TH_BORED  = 160,
   parameter int TH_SLEEPY = 224
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       tick,
   input  logic [7:0] rand_in,
   input  logic       event_ack,
   output logic       event_valid,
   output logic [1:0] event_id,
   output logic [3:0] miss_cnt,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARM     = 3'd1,
      S_COUNT   = 3'd2,
      S_PICK    = 3'd3,
      S_PENDING = 3'd4
   } state_t;

   localparam logic [8:0] c_min_gap   = 9'(MIN_GAP);
   localparam logic [8:0] c_th_hunger = 9'(TH_HUNGER);
   localparam logic [8:0] c_th_bored  = 9'(TH_BORED);
   localparam logic [8:0] c_th_sleepy = 9'(TH_SLEEPY);

   state_t     r_state,       w_state_nxt;
   logic [8:0] r_count,       w_count_nxt;
   logic       r_event_valid, w_event_valid_nxt;
   logic [1:0] r_event_id,    w_event_id_nxt;
   logic [3:0] r_miss_cnt,    w_miss_cnt_nxt;

   logic [8:0] w_arm_gap;
   logic [8:0] w_rand_ext;
   logic [1:0] w_pick_id;

   // 9-bit sum: MIN_GAP up to 255 plus up to 255 random ticks never wraps
   assign w_arm_gap  = c_min_gap + 9'(rand_in[GAP_BITS-1:0]);
   assign w_rand_ext = {1'b0, rand_in};

   always_comb begin
      w_pick_id = 2'd3;
      if (w_rand_ext < c_th_hunger)
         w_pick_id = 2'd0;
      else if (w_rand_ext < c_th_bored)
         w_pick_id = 2'd1;
      else if (w_rand_ext < c_th_sleepy)
         w_pick_id = 2'd2;
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_count_nxt       = r_count;
      w_event_valid_nxt = r_event_valid;
      w_event_id_nxt    = r_event_id;
      w_miss_cnt_nxt    = r_miss_cnt;
      case (r_state)
         S_IDLE: begin
            if (enable)
               w_state_nxt = S_ARM;
         end
         S_ARM: begin
            w_count_nxt = w_arm_gap;
            w_state_nxt = S_COUNT;
         end
         S_COUNT: begin
            // Disabling abandons the interval even when a tick arrives together
            if (!enable) begin
               w_state_nxt = S_IDLE;
               w_count_nxt = 9'd0;
            end else if (tick) begin
               if (r_count == 9'd1) begin
                  w_state_nxt = S_PICK;
                  w_count_nxt = 9'd0;
               end else begin
                  w_count_nxt = r_count - 9'd1;
               end
            end
         end
         S_PICK: begin
            w_event_id_nxt    = w_pick_id;
            w_event_valid_nxt = 1'b1;
            w_state_nxt       = S_PENDING;
         end
         S_PENDING: begin
            if (event_ack) begin
               w_event_valid_nxt = 1'b0;
               w_miss_cnt_nxt    = 4'd0;
               w_state_nxt       = enable ? S_ARM : S_IDLE;
            end else if (tick && (r_miss_cnt != 4'd15)) begin
               w_miss_cnt_nxt = r_miss_cnt + 4'd1;
            end
         end
         default: begin
            w_state_nxt       = S_IDLE;
            w_count_nxt       = 9'd0;
            w_event_valid_nxt = 1'b0;
            w_miss_cnt_nxt    = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_count       <= 9'd0;
         r_event_valid <= 1'b0;
         r_event_id    <= 2'd0;
         r_miss_cnt    <= 4'd0;
      end else begin
         r_state       <= w_state_nxt;
         r_count       <= w_count_nxt;
         r_event_valid <= w_event_valid_nxt;
         r_event_id    <= w_event_id_nxt;
         r_miss_cnt    <= w_miss_cnt_nxt;
      end
   end

   assign event_valid = r_event_valid;
   assign event_id    = r_event_id;
   assign miss_cnt    = r_miss_cnt;
   assign busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire
